// File: rtl/window_stream_gen_pkg.sv
// Shared types for the sliding-window stream generator: FSM state and stride encoding.
package window_stream_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef enum logic {
    STRIDE_1 = 1'b0,
    STRIDE_2 = 1'b1
  } stride_e;

  function automatic logic [1:0] stride_step(input stride_e s);
    return (s == STRIDE_2) ? 2'd2 : 2'd1;
  endfunction

endpackage

// File: rtl/win_line_buffer.sv
// One row of pixel history: one address per cycle, old word read out while the new one is written.
module win_line_buffer
  import window_stream_gen_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int MAX_COLS = 64,
  parameter int AW       = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem_r [MAX_COLS];

  // write port; contents need no reset
  always_ff @(posedge clk) begin
    if (en) begin
      mem_r[addr] <= wdata;
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/window_stream_gen.sv
// Raster pixel stream in, KSIZE x KSIZE windows out (stride 1 or 2), one-deep output register.
module window_stream_gen
  import window_stream_gen_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int KSIZE    = 3,
  parameter int MAX_COLS = 64,
  parameter int DIM_W    = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [DIM_W-1:0]             col_size,
  input  logic [DIM_W-1:0]             row_size,
  input  logic [7:0]                   num_layers,
  input  logic                         stride2en,
  input  logic [PIX_W-1:0]             s_pix,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [KSIZE*KSIZE*PIX_W-1:0] m_window,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err
);

  localparam int AW    = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int WIN_W = KSIZE * KSIZE * PIX_W;
  localparam logic [DIM_W:0]   K_D    = (DIM_W+1)'(KSIZE);
  localparam logic [DIM_W:0]   KM1_D  = (DIM_W+1)'(KSIZE - 1);
  localparam logic [DIM_W:0]   MAXC_D = (DIM_W+1)'(MAX_COLS);
  localparam logic [DIM_W-1:0] ONE_D  = DIM_W'(1);

  state_e            state_r, state_next_s;
  logic [DIM_W-1:0]  col_size_r, row_size_r, col_r, row_r;
  logic [7:0]        layers_r, layer_r;
  stride_e           stride_r;
  logic [PIX_W-1:0]  win_r      [KSIZE][KSIZE];
  logic [PIX_W-1:0]  win_next_s [KSIZE][KSIZE];
  logic [PIX_W-1:0]  lb_rdata_s [KSIZE-1];
  logic [PIX_W-1:0]  lb_wdata_s [KSIZE-1];
  logic [WIN_W-1:0]  win_packed_s, m_window_r;
  logic              m_valid_r, m_last_r, busy_r, done_r, cfg_err_r;
  logic              done_s, cfg_err_s;
  logic              cfg_ok_s, s_ready_s, accept_s;
  logic              col_end_s, row_end_s, layer_end_s;
  logic              emit_s, last_s, par_ok_s;
  logic [DIM_W:0]    step_s;

  assign cfg_ok_s    = ({1'b0, col_size} >= K_D) && ({1'b0, col_size} <= MAXC_D) &&
                       ({1'b0, row_size} >= K_D) && (num_layers != 8'd0);
  assign s_ready_s   = (state_r == ST_RUN) && (!m_valid_r || m_ready);
  assign accept_s    = s_valid && s_ready_s;
  assign col_end_s   = (col_r == col_size_r - ONE_D);
  assign row_end_s   = (row_r == row_size_r - ONE_D);
  assign layer_end_s = (layer_r == layers_r - 8'd1);
  assign step_s      = (DIM_W+1)'(stride_step(stride_r));

  // stride 2 keeps only windows whose offset from the first valid position is even
  assign par_ok_s = (stride_r == STRIDE_1) ||
                    ((row_r[0] == KM1_D[0]) && (col_r[0] == KM1_D[0]));
  assign emit_s   = ({1'b0, row_r} >= KM1_D) && ({1'b0, col_r} >= KM1_D) && par_ok_s;
  assign last_s   = ({1'b0, row_r} + step_s >= {1'b0, row_size_r}) &&
                    ({1'b0, col_r} + step_s >= {1'b0, col_size_r});

  genvar g;
  for (g = 0; g < KSIZE - 1; g++) begin : g_lb
    if (g == 0) begin : g_first
      assign lb_wdata_s[g] = s_pix;
    end else begin : g_chain
      assign lb_wdata_s[g] = lb_rdata_s[g-1];
    end
    win_line_buffer #(.PIX_W(PIX_W), .MAX_COLS(MAX_COLS), .AW(AW)) u_lb (
      .clk   (clk),
      .en    (accept_s),
      .addr  (AW'(col_r)),
      .wdata (lb_wdata_s[g]),
      .rdata (lb_rdata_s[g])
    );
  end

  // shift window left and insert the new column (oldest row from the deepest buffer)
  always_comb begin
    win_next_s = win_r;
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE - 1; j++) begin
        win_next_s[i][j] = win_r[i][j+1];
      end
    end
    for (int i = 0; i < KSIZE - 1; i++) begin
      win_next_s[i][KSIZE-1] = lb_rdata_s[KSIZE-2-i];
    end
    win_next_s[KSIZE-1][KSIZE-1] = s_pix;
  end

  // flatten the next window into the output packing
  always_comb begin
    win_packed_s = '0;
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE; j++) begin
        win_packed_s[(i*KSIZE+j)*PIX_W +: PIX_W] = win_next_s[i][j];
      end
    end
  end

  // window shift register
  always_ff @(posedge clk) begin
    if (accept_s) begin
      win_r <= win_next_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && cfg_ok_s) state_next_s = ST_RUN;
        else                   state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (accept_s && col_end_s && row_end_s && layer_end_s) state_next_s = ST_DRAIN;
        else                                                   state_next_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (!m_valid_r) state_next_s = ST_IDLE;
        else            state_next_s = ST_DRAIN;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    done_s    = 1'b0;
    cfg_err_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !cfg_ok_s) cfg_err_s = 1'b1;
        else                    cfg_err_s = 1'b0;
      end
      ST_RUN: begin
        done_s = 1'b0;
      end
      ST_DRAIN: begin
        if (!m_valid_r) done_s = 1'b1;
        else            done_s = 1'b0;
      end
      default: begin
        done_s    = 1'b0;
        cfg_err_s = 1'b0;
      end
    endcase
  end

  // status flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      busy_r    <= (state_next_s != ST_IDLE);
      done_r    <= done_s;
      cfg_err_r <= cfg_err_s;
    end
  end

  // job configuration and raster position counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_size_r <= '0;
      row_size_r <= '0;
      layers_r   <= 8'd0;
      stride_r   <= STRIDE_1;
      col_r      <= '0;
      row_r      <= '0;
      layer_r    <= 8'd0;
    end else if ((state_r == ST_IDLE) && start && cfg_ok_s) begin
      col_size_r <= col_size;
      row_size_r <= row_size;
      layers_r   <= num_layers;
      stride_r   <= stride2en ? STRIDE_2 : STRIDE_1;
      col_r      <= '0;
      row_r      <= '0;
      layer_r    <= 8'd0;
    end else if (accept_s) begin
      if (col_end_s) begin
        col_r <= '0;
        if (row_end_s) begin
          row_r   <= '0;
          layer_r <= layer_r + 8'd1;
        end else begin
          row_r <= row_r + ONE_D;
        end
      end else begin
        col_r <= col_r + ONE_D;
      end
    end
  end

  // output register: a new window may replace one being consumed in the same cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_window_r <= '0;
      m_valid_r  <= 1'b0;
      m_last_r   <= 1'b0;
    end else if (accept_s && emit_s) begin
      m_window_r <= win_packed_s;
      m_valid_r  <= 1'b1;
      m_last_r   <= last_s;
    end else if (m_ready) begin
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
    end
  end

  assign s_ready  = s_ready_s;
  assign m_window = m_window_r;
  assign m_valid  = m_valid_r;
  assign m_last   = m_last_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign cfg_err  = cfg_err_r;

endmodule

// File: tb/tb_window_stream_gen.sv
// Directed bench for window_stream_gen: table of jobs, bad-config and mid-job reset sequences.
module tb_window_stream_gen;

  localparam int PIX_W = 8;
  localparam int KSIZE = 3;
  localparam int WIN_W = KSIZE * KSIZE * PIX_W;

  logic             clk = 1'b0;
  logic             reset_n, start, stride2en, s_valid, s_ready;
  logic             m_valid, m_ready, m_last, busy, done, cfg_err;
  logic [7:0]       col_size, row_size, num_layers, s_pix;
  logic [WIN_W-1:0] m_window;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  window_stream_gen #(.PIX_W(PIX_W), .KSIZE(KSIZE), .MAX_COLS(64), .DIM_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .col_size(col_size), .row_size(row_size),
    .num_layers(num_layers), .stride2en(stride2en), .s_pix(s_pix), .s_valid(s_valid),
    .s_ready(s_ready), .m_window(m_window), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  typedef struct packed {
    int cols;
    int rows;
    int layers;
    int stride;
    int toggle;
    int exp_count;
    int first_tl;
    int last_tl;
  } vec_t;

  vec_t vecs [5];

  logic [WIN_W-1:0] got_win [$];
  bit               got_last [$];
  logic [WIN_W-1:0] exp_win [$];
  bit               exp_last [$];

  task automatic chk(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix_of(input int l, input int r, input int c, input int cols, input int rows);
    return 8'((l * 50 + r * cols + c) % 256);
  endfunction

  function automatic logic [7:0] elem(input logic [WIN_W-1:0] w, input int i, input int j);
    return w[(i*KSIZE+j)*PIX_W +: PIX_W];
  endfunction

  task automatic build_expected(input vec_t v);
    int s, last_r, last_c;
    logic [WIN_W-1:0] w;
    s = (v.stride != 0) ? 2 : 1;
    last_r = (KSIZE - 1) + s * ((v.rows - KSIZE) / s);
    last_c = (KSIZE - 1) + s * ((v.cols - KSIZE) / s);
    exp_win.delete();
    exp_last.delete();
    for (int l = 0; l < v.layers; l++)
      for (int r = KSIZE - 1; r < v.rows; r += s)
        for (int c = KSIZE - 1; c < v.cols; c += s) begin
          w = '0;
          for (int i = 0; i < KSIZE; i++)
            for (int j = 0; j < KSIZE; j++)
              w[(i*KSIZE+j)*PIX_W +: PIX_W] = pix_of(l, r - KSIZE + 1 + i, c - KSIZE + 1 + j, v.cols, v.rows);
          exp_win.push_back(w);
          exp_last.push_back((r == last_r) && (c == last_c));
        end
  endtask

  // runs one job; abort_after >= 0 stops feeding once that many pixels were accepted
  task automatic run_job(input int idx, input int abort_after);
    vec_t v;
    int pix_idx, total, cyc, done_cnt, cfg_cnt, l, rem, extra_win, n, min_px;
    bit prev_stall;
    logic [WIN_W-1:0] prev_win;
    logic prev_last;
    int req31_first [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    v = vecs[idx];
    build_expected(v);
    got_win.delete();
    got_last.delete();
    @(negedge clk);
    start = 1'b1;
    col_size = 8'(v.cols);
    row_size = 8'(v.rows);
    num_layers = 8'(v.layers);
    stride2en = (v.stride != 0);
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("busy_after_start[%0d]", idx), busy, 1);
    col_size = 8'd2;
    row_size = 8'd3;
    stride2en = ~stride2en;
    pix_idx = 0; total = v.cols * v.rows * v.layers; cyc = 0;
    done_cnt = 0; cfg_cnt = 0; prev_stall = 0; prev_win = '0; prev_last = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      @(negedge clk);
      if (abort_after >= 0 && pix_idx == abort_after) break;
      start = (cyc == 2);
      m_ready = (v.toggle != 0) ? (cyc % 2 == 0) : 1'b1;
      if (pix_idx < total) begin
        l = pix_idx / (v.cols * v.rows);
        rem = pix_idx % (v.cols * v.rows);
        s_valid = 1'b1;
        s_pix = pix_of(l, rem / v.cols, rem % v.cols, v.cols, v.rows);
      end else begin
        s_valid = 1'b0;
      end
      #4;
      if (prev_stall) begin
        chk("window_stable_in_stall", m_window, prev_win);
        chk("last_stable_in_stall", m_last, prev_last);
      end
      if (m_valid && !m_ready) chk("s_ready_low_when_full", s_ready, 0);
      prev_stall = m_valid && !m_ready;
      prev_win = m_window;
      prev_last = m_last;
      if (m_valid && m_ready) begin
        got_win.push_back(m_window);
        got_last.push_back(m_last);
      end
      if (s_valid && s_ready) pix_idx++;
      if (done) done_cnt++;
      if (cfg_err) cfg_cnt++;
      cyc++;
    end
    start = 1'b0;
    s_valid = 1'b0;
    if (abort_after >= 0) return;
    extra_win = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m_ready = 1'b1;
      #4;
      if (done) done_cnt++;
      if (m_valid) extra_win++;
    end
    chk($sformatf("done_pulses[%0d]", idx), done_cnt, 1);
    chk($sformatf("cfg_err_ignored_in_run[%0d]", idx), cfg_cnt, 0);
    chk($sformatf("no_window_after_done[%0d]", idx), extra_win, 0);
    chk($sformatf("busy_after_done[%0d]", idx), busy, 0);
    chk($sformatf("window_count[%0d]", idx), got_win.size(), v.exp_count);
    n = (got_win.size() < exp_win.size()) ? got_win.size() : exp_win.size();
    for (int k = 0; k < n; k++) begin
      chk($sformatf("window[%0d][%0d]", idx, k), got_win[k], exp_win[k]);
      chk($sformatf("m_last[%0d][%0d]", idx, k), got_last[k], exp_last[k]);
    end
    if (got_win.size() > 0) begin
      for (int i = 0; i < KSIZE; i++)
        for (int j = 0; j < KSIZE; j++) begin
          chk($sformatf("first_elem[%0d](%0d,%0d)", idx, i, j), elem(got_win[0], i, j),
              8'(v.first_tl + i * v.cols + j));
          chk($sformatf("last_elem[%0d](%0d,%0d)", idx, i, j), elem(got_win[got_win.size()-1], i, j),
              8'(v.last_tl + i * v.cols + j));
        end
      chk($sformatf("final_m_last[%0d]", idx), got_last[got_last.size()-1], 1);
      if (idx == 0)
        for (int e = 0; e < 9; e++)
          chk($sformatf("first_window_list[%0d]", e), got_win[0][e*PIX_W +: PIX_W], 8'(req31_first[e]));
      if (v.layers == 2 && got_win.size() > 4) begin
        chk("layer1_m_last_4th", got_last[3], 1);
        min_px = 255;
        for (int e = 0; e < 9; e++)
          if (int'(got_win[4][e*PIX_W +: PIX_W]) < min_px) min_px = int'(got_win[4][e*PIX_W +: PIX_W]);
        chk("layer2_first_only_layer2", (min_px >= 50), 1);
      end
    end
  endtask

  task automatic cfg_case(input string name, input int cols, input int rows, input int layers);
    @(negedge clk);
    start = 1'b1;
    col_size = 8'(cols);
    row_size = 8'(rows);
    num_layers = 8'(layers);
    stride2en = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_cfg_err"}, cfg_err, 1);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_s_ready"}, s_ready, 0);
    @(negedge clk);
    chk({name, "_cfg_err_pulse_end"}, cfg_err, 0);
    chk({name, "_busy_after"}, busy, 0);
  endtask

  initial begin
    vecs[0] = '{cols: 5, rows: 5, layers: 1, stride: 0, toggle: 0, exp_count: 9, first_tl: 0, last_tl: 12};
    vecs[1] = '{cols: 5, rows: 5, layers: 1, stride: 1, toggle: 0, exp_count: 4, first_tl: 0, last_tl: 12};
    vecs[2] = '{cols: 5, rows: 5, layers: 1, stride: 0, toggle: 1, exp_count: 9, first_tl: 0, last_tl: 12};
    vecs[3] = '{cols: 4, rows: 4, layers: 2, stride: 0, toggle: 0, exp_count: 8, first_tl: 0, last_tl: 55};
    vecs[4] = '{cols: 6, rows: 5, layers: 1, stride: 1, toggle: 1, exp_count: 4, first_tl: 0, last_tl: 14};

    reset_n = 1'b0; start = 1'b0; stride2en = 1'b0; s_valid = 1'b0; s_pix = 8'd0;
    m_ready = 1'b1; col_size = 8'd0; row_size = 8'd0; num_layers = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_last", m_last, 0);
    chk("reset_s_ready", s_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cfg_err", cfg_err, 0);
    reset_n = 1'b1;

    for (int t = 0; t < 5; t++) run_job(t, -1);

    cfg_case("cols_below_k", 2, 5, 1);
    cfg_case("cols_above_max", 65, 5, 1);
    cfg_case("rows_below_k", 5, 2, 1);
    cfg_case("zero_layers", 5, 5, 0);

    run_job(0, 12);
    @(negedge clk);
    reset_n = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("midjob_reset_m_valid", m_valid, 0);
    chk("midjob_reset_busy", busy, 0);
    chk("midjob_reset_s_ready", s_ready, 0);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("no_window_after_reset[%0d]", k), m_valid, 0);
    end
    run_job(0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_stream_gen.md
WINDOW_STREAM_GEN -- requirements
Module: window_stream_gen

Interface
REQ-001 SHALL have parameter PIX_W, default 8, meaning bits per pixel.
REQ-002 SHALL have parameter KSIZE, default 3, meaning window edge (KSIZE x KSIZE), legal range 2..7.
REQ-003 SHALL have parameter MAX_COLS, default 64, meaning line-buffer depth (max row length).
REQ-004 SHALL have parameter DIM_W, default 8, meaning width of row/col size fields.
REQ-005 SHALL have ports clk in 1 (clock) and reset_n in 1 (reset, synchronous, active-low).
REQ-006 SHALL have ports start in 1 (begin job pulse), col_size in DIM_W (pixels per row), row_size in DIM_W (rows per layer), num_layers in 8 (layers per job), stride2en in 1 (stride 2 when 1).
REQ-007 SHALL have ports s_pix in PIX_W (raster pixel), s_valid in 1, s_ready out 1.
REQ-008 SHALL have ports m_window out KSIZE*KSIZE*PIX_W, m_valid out 1, m_ready in 1, m_last out 1 (last window of a layer).
REQ-009 SHALL have ports busy out 1, done out 1 (one-cycle job-complete pulse), cfg_err out 1 (one-cycle bad-config pulse).

Function
REQ-010 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-011 In IDLE, start with KSIZE<=col_size<=MAX_COLS, row_size>=KSIZE and num_layers>=1 SHALL latch all config and enter RUN. Otherwise start SHALL pulse cfg_err and remain IDLE.
REQ-012 start outside IDLE SHALL be ignored.
REQ-013 Pixels arrive raster order, layer after layer. Row, column and layer counters SHALL advance only on s_valid&&s_ready.
REQ-014 s_ready SHALL be 1 only in RUN and while the output register is empty or m_ready is 1.
REQ-015 Block SHALL keep KSIZE-1 line buffers of MAX_COLS x PIX_W plus a KSIZE x KSIZE shift-register window.
REQ-016 The window SHALL be emitted when the accepted pixel at (r,c) has r>=KSIZE-1 and c>=KSIZE-1. With stride2en=1, (r-KSIZE+1) and (c-KSIZE+1) SHALL both also be even.
REQ-017 Windows per layer SHALL be ((row_size-KSIZE)/S+1)*((col_size-KSIZE)/S+1), with S=1 or 2 and floor division.
REQ-018 Element (i,j), i=row with 0=oldest and j=col with 0=leftmost, SHALL be packed at m_window[(i*KSIZE+j)*PIX_W +: PIX_W].
REQ-019 m_valid SHALL rise the cycle after the handshake of the window's bottom-right pixel (latency 1).
REQ-020 m_window and m_last SHALL hold stable while m_valid&&!m_ready.
REQ-021 m_last SHALL be 1 only with the final window of each layer.
REQ-022 Column wrap SHALL reset the column counter to 0 and increment the row counter. Row wrap SHALL reset the row counter to 0, increment the layer counter and discard line-buffer history: no window spans two layers.
REQ-023 Acceptance of the last pixel of the last layer SHALL enter DRAIN. DRAIN SHALL exit to IDLE once the output register is empty, pulsing done for one cycle in that transition.
REQ-024 busy SHALL be 1 in RUN and DRAIN.
REQ-025 Simultaneous output consume and new-window load SHALL overwrite the register with no bubble.

Reset
REQ-026 reset_n=0 at a clk edge SHALL force IDLE and clear all counters, plus m_valid, m_last, s_ready, busy, done and cfg_err, to 0.
REQ-027 Reset mid-job SHALL abandon the job; no window may appear after reset.
REQ-028 Line-buffer contents SHALL need no reset.

Structure
REQ-029 A shared package SHALL hold the FSM state enum and the stride encoding.
REQ-030 Line storage SHALL be one sub-module, win_line_buffer: single-port-per-cycle RAM, MAX_COLS x PIX_W, instantiated KSIZE-1 times.

Verification
REQ-031 5x5, K=3, stride1, pix=r*5+c, m_ready=1 -> 9 windows. First window = {0,1,2,5,6,7,10,11,12}; last = {12,13,14,17,18,19,22,23,24} with m_last=1; done pulses once.
REQ-032 Same input with stride2en=1 -> 4 windows with top-left pixels 0, 2, 10, 12; m_last on the 4th.
REQ-033 5x5 stride1 with m_ready toggling 1-0 each cycle -> identical 9 windows. m_window stable while stalled. s_ready=0 whenever output is full and m_ready=0.
REQ-034 num_layers=2, 4x4, K=3 -> 8 windows with m_last on the 4th and 8th. First window of layer 2 contains only layer-2 pixels.
REQ-035 start with col_size=2 (K=3) -> cfg_err pulse, busy stays 0, s_ready stays 0.
REQ-036 reset_n=0 after 12 pixels of a 5x5 job -> next cycle m_valid=0, busy=0. A following fresh job reproduces the REQ-031 results exactly.
